alu_arbiter: RTL and testbench

Shares one combinational ALU instance between NUM_REQ requesters, e.g. the main datapath and the branch/address unit, using valid/ready handshakes. Round-robin grant, one operation in flight, registered result returned to the owning requester. Also tracks a sticky halt when the HALT opcode is executed. Sits between the requesters and the existing alu.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu.sv | 57 +++++
 rtl/alu_arbiter_rr_grant.sv | 43 ++++
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU and its requester arbiter.
//               Provides the ALU opcode encodings and the arbiter state type.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU operation encodings
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_HALT = 4'b0110;
    localparam logic [3:0] ALU_ADDI = 4'b0111;
    localparam logic [3:0] ALU_BEQ  = 4'b1000;
    localparam logic [3:0] ALU_SLLI = 4'b1001;
    localparam logic [3:0] ALU_SRLI = 4'b1010;
    localparam logic [3:0] ALU_SRAI = 4'b1011;
    localparam logic [3:0] ALU_BGE  = 4'b1100;
    localparam logic [3:0] ALU_BNE  = 4'b1101;
    localparam logic [3:0] ALU_BLT  = 4'b1110;
    localparam logic [3:0] ALU_JAL  = 4'b1111;

    // Arbiter FSM states
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational ALU.
//               Ports: srca/srcb  - operands
//                      operation  - opcode (see alu_pkg)
//                      alu_result - result; HALT and undefined codes give 0,
//                                   compare/branch ops give 1 or 0
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    srca,
    input  logic [DATA_WIDTH-1:0]    srcb,
    input  logic [OPCODE_LENGTH-1:0] operation,
    output logic [DATA_WIDTH-1:0]    alu_result
);

    localparam int C_SHAMT_W = $clog2(DATA_WIDTH);

    logic [C_SHAMT_W-1:0] w_shamt;
    logic                 w_slt;
    logic                 w_eq;

    assign w_shamt = srcb[C_SHAMT_W-1:0];
    assign w_slt   = ($signed(srca) < $signed(srcb));
    assign w_eq    = (srca == srcb);

    always_comb begin
        alu_result = '0;
        case (operation)
            OPCODE_LENGTH'(ALU_AND):  alu_result = srca & srcb;
            OPCODE_LENGTH'(ALU_OR):   alu_result = srca | srcb;
            OPCODE_LENGTH'(ALU_ADD):  alu_result = srca + srcb;
            OPCODE_LENGTH'(ALU_XOR):  alu_result = srca ^ srcb;
            OPCODE_LENGTH'(ALU_SUB):  alu_result = srca - srcb;
            OPCODE_LENGTH'(ALU_SLT):  alu_result = {{(DATA_WIDTH-1){1'b0}}, w_slt};
            OPCODE_LENGTH'(ALU_HALT): alu_result = '0;
            OPCODE_LENGTH'(ALU_ADDI): alu_result = srca + srcb;
            OPCODE_LENGTH'(ALU_BEQ):  alu_result = {{(DATA_WIDTH-1){1'b0}}, w_eq};
            OPCODE_LENGTH'(ALU_SLLI): alu_result = srca << w_shamt;
            OPCODE_LENGTH'(ALU_SRLI): alu_result = srca >> w_shamt;
            OPCODE_LENGTH'(ALU_SRAI): alu_result = DATA_WIDTH'($signed(srca) >>> w_shamt);
            OPCODE_LENGTH'(ALU_BGE):  alu_result = {{(DATA_WIDTH-1){1'b0}}, ~w_slt};
            OPCODE_LENGTH'(ALU_BNE):  alu_result = {{(DATA_WIDTH-1){1'b0}}, ~w_eq};
            OPCODE_LENGTH'(ALU_BLT):  alu_result = {{(DATA_WIDTH-1){1'b0}}, w_slt};
            OPCODE_LENGTH'(ALU_JAL):  alu_result = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            default:                  alu_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant
// Description : Combinational round-robin priority picker.
//               Ports: req        - request vector
//                      last_grant - index of the most recent winner
//                      grant      - one-hot winner (zero when no request)
//                      grant_idx  - binary index of the winner
//                      grant_any  - a winner exists
//               Search starts one above last_grant and wraps, so the most
//               recent winner has the lowest priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    int w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        w_idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(last_grant) + k) % NUM_REQ;
            if (!grant_any && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                grant_idx    = IDX_W'(w_idx);
                grant_any    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational ALU among NUM_REQ requesters with
//               valid/ready handshakes, round-robin grant and a single
//               operation in flight. The registered result is returned to
//               the requester that owns the operation. A HALT op sets a
//               sticky halted flag that blocks all further grants.
//               Ports: clk, reset (async, active-high)
//                      req_valid/req_ready        - request handshake
//                      req_srca/req_srcb/req_op   - packed per-requester ops
//                      rsp_valid/rsp_ready        - response handshake
//                      rsp_result                 - registered ALU result
//                      busy                       - an op is in flight
//                      halted                     - sticky HALT flag
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int NUM_REQ       = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb,
    input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
    output logic [NUM_REQ-1:0]               rsp_valid,
    input  logic [NUM_REQ-1:0]               rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_result,
    output logic                             busy,
    output logic                             halted
);

    localparam int C_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t              r_state;
    logic [C_IDX_W-1:0]      r_last_grant;
    logic [C_IDX_W-1:0]      r_owner;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_result;
    logic                    r_busy;
    logic                    r_halted;

    logic [NUM_REQ-1:0]       w_grant;
    logic [C_IDX_W-1:0]       w_grant_idx;
    logic                     w_grant_any;
    logic                     w_accept_en;
    logic                     w_fire;
    logic [DATA_WIDTH-1:0]    w_srca;
    logic [DATA_WIDTH-1:0]    w_srcb;
    logic [OPCODE_LENGTH-1:0] w_op;
    logic [DATA_WIDTH-1:0]    w_alu_result;
    logic                     w_owner_rsp_ready;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (C_IDX_W)
    ) u_rr_grant (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx),
        .grant_any  (w_grant_any)
    );

    // Grants are only offered in IDLE, never once halted, and never while
    // reset is asserted so that req_ready reads 0 throughout reset.
    assign w_accept_en = (r_state == IDLE) && !r_halted && !reset && w_grant_any;
    assign req_ready   = w_accept_en ? w_grant : '0;
    assign w_fire      = |(req_valid & req_ready);

    // One-hot operand mux; the grant vector is zero or one-hot, so OR-ing
    // the selected slices gives the winner's operands.
    always_comb begin
        w_srca = '0;
        w_srcb = '0;
        w_op   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_srca = w_srca | req_srca[i*DATA_WIDTH +: DATA_WIDTH];
                w_srcb = w_srcb | req_srcb[i*DATA_WIDTH +: DATA_WIDTH];
                w_op   = w_op   | req_op[i*OPCODE_LENGTH +: OPCODE_LENGTH];
            end
        end
    end

    alu #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_alu (
        .srca       (w_srca),
        .srcb       (w_srcb),
        .operation  (w_op),
        .alu_result (w_alu_result)
    );

    // Only the owner's rsp_ready bit can complete the response.
    assign w_owner_rsp_ready = rsp_ready[r_owner];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= C_IDX_W'(NUM_REQ - 1);
            r_owner      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_busy       <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        r_rsp_result <= w_alu_result;
                        r_owner      <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_rsp_valid  <= w_grant;
                        r_busy       <= 1'b1;
                        r_state      <= BUSY;
                        if (w_op == OPCODE_LENGTH'(ALU_HALT)) begin
                            r_halted <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (w_owner_rsp_ready) begin
                        r_rsp_valid <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign busy       = r_busy;
    assign halted     = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking directed bench for alu_arbiter. Expected
//               responses are pushed to a queue when a grant is expected
//               and popped when the DUT completes a response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int NR = 2;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_srca;
    logic [NR*DW-1:0]  req_srcb;
    logic [NR*OW-1:0]  req_op;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready;
    logic [DW-1:0]     rsp_result;
    logic              busy;
    logic              halted;

    alu_arbiter #(
        .DATA_WIDTH    (DW),
        .OPCODE_LENGTH (OW),
        .NUM_REQ       (NR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_srca   (req_srca),
        .req_srcb   (req_srcb),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .busy       (busy),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] owner;
        logic [DW-1:0] result;
    } sb_t;

    sb_t q[$];
    int  n_vec  = 0;
    int  n_fail = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference ALU for the opcodes used by this bench
    function automatic logic [DW-1:0] model(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            4'b0010: return a + b;
            4'b0100: return a - b;
            4'b0101: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1011: return DW'($signed(a) >>> b[4:0]);
            default: return '0;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_op[i*OW +: OW]   = op;
        req_srca[i*DW +: DW] = a;
        req_srcb[i*DW +: DW] = b;
        req_valid[i]         = 1'b1;
    endtask

    // One clock: check handshake outputs at the falling edge, update the
    // scoreboard, then return just after the next rising edge.
    task automatic cyc(input logic [NR-1:0] exp_ready, input logic [NR-1:0] exp_rspv);
        sb_t e;
        @(negedge clk);
        chk("req_ready", DW'(req_ready), DW'(exp_ready));
        chk("rsp_valid", DW'(rsp_valid), DW'(exp_rspv));
        chk("busy", DW'(busy), DW'(exp_rspv != '0));
        for (int i = 0; i < NR; i++) begin
            if (exp_ready[i]) begin
                e.owner  = NR'(1) << i;
                e.result = model(req_op[i*OW +: OW], req_srca[i*DW +: DW], req_srcb[i*DW +: DW]);
                q.push_back(e);
            end
        end
        if ((rsp_valid & rsp_ready) != '0) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", DW'(rsp_valid), '0);
            end else begin
                e = q.pop_front();
                chk("rsp_owner", DW'(rsp_valid), DW'(e.owner));
                chk("rsp_result", rsp_result, e.result);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_srca  = '0;
        req_srcb  = '0;
        req_op    = '0;
        rsp_ready = '0;

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", DW'(req_ready), '0);
        chk("rst_rsp_valid", DW'(rsp_valid), '0);
        chk("rst_rsp_result", rsp_result, '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_halted", DW'(halted), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single ADD from requester 0
        set_req(0, 4'b0010, 32'd5, 32'd7);
        rsp_ready = 2'b01;
        cyc(2'b01, 2'b00);
        req_valid = '0;
        cyc(2'b00, 2'b01);
        cyc(2'b00, 2'b00);

        // Both valid continuously: rotation continues from last winner (0)
        set_req(0, 4'b0100, 32'd10, 32'd3);
        set_req(1, 4'b1011, 32'h8000_0000, 32'd4);
        rsp_ready = 2'b11;
        for (int r = 0; r < 2; r++) begin
            cyc(2'b10, 2'b00);
            cyc(2'b00, 2'b10);
            cyc(2'b01, 2'b00);
            cyc(2'b00, 2'b01);
        end
        req_valid = '0;

        // Backpressure on requester 1
        set_req(1, 4'b0101, 32'hFFFF_FFFF, 32'd1);
        rsp_ready = 2'b00;
        cyc(2'b10, 2'b00);
        req_valid = '0;
        for (int r = 0; r < 5; r++) begin
            cyc(2'b00, 2'b10);
            chk("bp_result_hold", rsp_result, 32'd1);
        end
        rsp_ready = 2'b10;
        cyc(2'b00, 2'b10);
        cyc(2'b00, 2'b00);

        // Non-owner rsp_ready is ignored
        set_req(0, 4'b0010, 32'd1, 32'd2);
        rsp_ready = 2'b10;
        cyc(2'b01, 2'b00);
        req_valid = '0;
        for (int r = 0; r < 3; r++) begin
            cyc(2'b00, 2'b01);
        end
        rsp_ready = 2'b01;
        cyc(2'b00, 2'b01);
        cyc(2'b00, 2'b00);

        // HALT: response delivered, then no grants until reset
        set_req(0, 4'b0110, 32'd9, 32'd9);
        cyc(2'b01, 2'b00);
        req_valid = '0;
        chk("halt_set", DW'(halted), 32'd1);
        cyc(2'b00, 2'b01);
        set_req(1, 4'b0010, 32'd3, 32'd4);
        rsp_ready = 2'b00;
        for (int r = 0; r < 6; r++) begin
            cyc(2'b00, 2'b00);
            chk("halt_sticky", DW'(halted), 32'd1);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("halt_cleared", DW'(halted), '0);

        // Async reset while BUSY discards the op
        set_req(0, 4'b0010, 32'd100, 32'd23);
        set_req(1, 4'b0100, 32'd50, 32'd8);
        reset = 1'b0;
        cyc(2'b01, 2'b00);
        cyc(2'b00, 2'b01);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_rsp_valid", DW'(rsp_valid), '0);
        chk("arst_busy", DW'(busy), '0);
        chk("arst_rsp_result", rsp_result, '0);
        chk("arst_req_ready", DW'(req_ready), '0);
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        rsp_ready = 2'b11;
        cyc(2'b01, 2'b00);
        cyc(2'b00, 2'b01);
        cyc(2'b10, 2'b00);
        req_valid = '0;
        cyc(2'b00, 2'b10);
        cyc(2'b00, 2'b00);
        chk("sb_drained", DW'(q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
